// File: rtl/computer_pkg.sv
// Shared types for the unified memory subsystem: word width, FSM/channel
// enums and the byte-lane merge used for partial writes.
package computer_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = WORD_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        INST = 1'b0,
        DATA = 1'b1
    } chan_t;

    // Replace each byte lane of old_word whose enable bit is set.
    function automatic logic [WORD_W-1:0] be_merge(
        input logic [WORD_W-1:0] old_word,
        input logic [WORD_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [WORD_W-1:0] merged;
        merged = old_word;
        for (int n = 0; n < BE_W; n++) begin
            merged[8*n +: 8] = be[n] ? new_word[8*n +: 8] : old_word[8*n +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/sc_word_ram.sv
// Single-port DEPTH x 32 word array: clocked byte-lane writes, combinational
// read of the addressed word.
module sc_word_ram
    import computer_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter     INIT_FILE = "",
    parameter int IDX_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [BE_W-1:0]   i_be,
    input  logic [IDX_W-1:0]  i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];

    // Per-lane write so each byte maps onto a byte-write-enable column.
    always_ff @(posedge clk) begin
        for (int n = 0; n < BE_W; n++) begin
            if (i_we && i_be[n]) begin
                r_mem[i_addr][8*n +: 8] <= i_wdata[8*n +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/computer_mem_system.sv
// Unified instruction/data memory with req/ack handshake, WAIT_CYCLES wait
// states and alternating-priority arbitration. Optional macro MMIO_OUT_EN maps
// data accesses at MMIO_ADDR onto the mmio_out register.
module computer_mem_system
    import computer_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH       = 1024,
    parameter int                WAIT_CYCLES = 2,
    parameter                    INIT_FILE   = "",
    parameter logic [ADDR_W-1:0] MMIO_ADDR   = 32'h0000_FFFC
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [WORD_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [BE_W-1:0]   d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic [WORD_W-1:0] d_rdata,
    output logic              d_ack,
    output logic [WORD_W-1:0] mmio_out
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t            r_state;
    chan_t             r_last_grant;
    chan_t             r_chan;
    logic [3:0]        r_wait_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic              r_we;
    logic [BE_W-1:0]   r_be;
    logic [WORD_W-1:0] r_wdata;
    logic              r_hit;
    logic              r_i_ack;
    logic              r_d_ack;
    logic [WORD_W-1:0] r_i_rdata;
    logic [WORD_W-1:0] r_d_rdata;

    logic              w_pick_data;
    logic              w_any_req;
    logic              w_hit_live;
    logic              w_fire;
    chan_t             w_acc_chan;
    logic [IDX_W-1:0]  w_acc_idx;
    logic              w_acc_we;
    logic [BE_W-1:0]   w_acc_be;
    logic [WORD_W-1:0] w_acc_wdata;
    logic              w_acc_hit;
    logic [WORD_W-1:0] w_ram_rdata;
    logic [WORD_W-1:0] w_mmio_q;
    logic [WORD_W-1:0] w_old_word;
    logic [WORD_W-1:0] w_new_word;
    logic              w_ram_we;
    logic              w_unused;

    // Only the word-index bits (and the MMIO compare) consume the addresses.
    assign w_unused = ^{i_addr, d_addr};

`ifdef MMIO_OUT_EN
    logic [WORD_W-1:0] r_mmio;

    assign w_hit_live = (d_addr[ADDR_W-1:2] == MMIO_ADDR[ADDR_W-1:2]);
    assign w_mmio_q   = r_mmio;

    // Output register written through the data channel at its access edge.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_mmio <= 32'h0000_0000;
        end else if (w_fire && w_acc_hit && w_acc_we) begin
            r_mmio <= w_new_word;
        end else begin
            r_mmio <= r_mmio;
        end
    end
`else
    assign w_hit_live = 1'b0;
    assign w_mmio_q   = 32'h0000_0000;
`endif

    assign mmio_out = w_mmio_q;

    // Access parameters come from live inputs in IDLE so WAIT_CYCLES=0 can
    // complete straight from the grant edge; otherwise from the latched copy.
    always_comb begin
        w_pick_data = d_req && (!i_req || (r_last_grant == INST));
        w_any_req   = i_req || d_req;
        if (r_state == IDLE) begin
            w_acc_chan  = w_pick_data ? DATA : INST;
            w_acc_idx   = w_pick_data ? d_addr[IDX_W+1:2] : i_addr[IDX_W+1:2];
            w_acc_we    = w_pick_data && d_we;
            w_acc_be    = d_be;
            w_acc_wdata = d_wdata;
            w_acc_hit   = w_pick_data && w_hit_live;
        end else begin
            w_acc_chan  = r_chan;
            w_acc_idx   = r_idx;
            w_acc_we    = r_we;
            w_acc_be    = r_be;
            w_acc_wdata = r_wdata;
            w_acc_hit   = r_hit;
        end
        case (r_state)
            IDLE:    w_fire = w_any_req && (WAIT_CYCLES == 0);
            WAIT:    w_fire = (r_wait_cnt == 4'd1);
            default: w_fire = 1'b0;
        endcase
        w_old_word = w_acc_hit ? w_mmio_q : w_ram_rdata;
        w_new_word = be_merge(w_old_word, w_acc_wdata, w_acc_we ? w_acc_be : 4'b0000);
        w_ram_we   = w_fire && w_acc_we && !w_acc_hit;
    end

    sc_word_ram #(
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_be    (w_acc_be),
        .i_addr  (w_acc_idx),
        .i_wdata (w_acc_wdata),
        .o_rdata (w_ram_rdata)
    );

    // Arbiter/sequencer FSM; ack and rdata register on the edge entering RESP.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state      <= IDLE;
            r_last_grant <= INST;
            r_chan       <= INST;
            r_wait_cnt   <= 4'd0;
            r_idx        <= '0;
            r_we         <= 1'b0;
            r_be         <= 4'b0000;
            r_wdata      <= 32'h0000_0000;
            r_hit        <= 1'b0;
            r_i_ack      <= 1'b0;
            r_d_ack      <= 1'b0;
            r_i_rdata    <= 32'h0000_0000;
            r_d_rdata    <= 32'h0000_0000;
        end else begin
            r_i_ack <= 1'b0;
            r_d_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_chan     <= w_acc_chan;
                        r_idx      <= w_acc_idx;
                        r_we       <= w_acc_we;
                        r_be       <= w_acc_be;
                        r_wdata    <= w_acc_wdata;
                        r_hit      <= w_acc_hit;
                        r_wait_cnt <= 4'(WAIT_CYCLES);
                        r_state    <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                WAIT: begin
                    r_wait_cnt <= r_wait_cnt - 4'd1;
                    r_state    <= (r_wait_cnt == 4'd1) ? RESP : WAIT;
                end
                RESP: begin
                    r_last_grant <= r_chan;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
            if (w_fire) begin
                if (w_acc_chan == DATA) begin
                    r_d_ack   <= 1'b1;
                    r_d_rdata <= w_new_word;
                end else begin
                    r_i_ack   <= 1'b1;
                    r_i_rdata <= w_new_word;
                end
            end
        end
    end

    assign i_ack   = r_i_ack;
    assign d_ack   = r_d_ack;
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;

endmodule

// File: tb/tb_computer_mem_system.sv
// Directed bench for computer_mem_system (defaults: WAIT_CYCLES=2, DEPTH=1024):
// vector table of single accesses plus reset, abort, arbitration and MMIO sequences.
module tb_computer_mem_system;

    logic        clk;
    logic        clrn;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic [31:0] mmio_out;

    int n_vec = 0;
    int n_bad = 0;

    computer_mem_system dut (
        .clk      (clk),
        .clrn     (clrn),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .i_ack    (i_ack),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_be     (d_be),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_ack    (d_ack),
        .mmio_out (mmio_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ch;     // 1 = data channel, 0 = fetch channel
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One handshake; starts in an IDLE cycle so latency counts from the request cycle.
    task automatic do_access(input logic ch, input logic we, input logic [3:0] be,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata, output int lat);
        @(posedge clk); #1;
        lat   = 0;
        rdata = 'x;
        if (ch) begin
            d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (ch ? d_ack : i_ack) begin
                lat   = c;
                rdata = ch ? d_rdata : i_rdata;
                break;
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        logic        seen;
        int          n_got;
        int          g_ch  [3];
        int          g_cyc [3];
        logic [31:0] g_dat [3];
        logic        dual;

        vecs[0]  = '{1'b1, 1'b1, 4'hF, 32'd16,         32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 1'b0, 4'h0, 32'd16,         32'h0,        32'hDEADBEEF};
        vecs[2]  = '{1'b1, 1'b1, 4'hF, 32'd8,          32'hAABBCCDD, 32'hAABBCCDD};
        vecs[3]  = '{1'b1, 1'b1, 4'h5, 32'd8,          32'h11223344, 32'hAA22CC44};
        vecs[4]  = '{1'b1, 1'b0, 4'h0, 32'd8,          32'h0,        32'hAA22CC44};
        vecs[5]  = '{1'b1, 1'b1, 4'h0, 32'd8,          32'hFFFFFFFF, 32'hAA22CC44};
        vecs[6]  = '{1'b0, 1'b0, 4'h0, 32'd11,         32'h0,        32'hAA22CC44};
        vecs[7]  = '{1'b1, 1'b1, 4'hF, 32'h0000_1000,  32'hCAFEF00D, 32'hCAFEF00D};
        vecs[8]  = '{1'b1, 1'b0, 4'h0, 32'h0000_0000,  32'h0,        32'hCAFEF00D};
        vecs[9]  = '{1'b0, 1'b0, 4'h0, 32'hFFFF_F000,  32'h0,        32'hCAFEF00D};
        vecs[10] = '{1'b1, 1'b1, 4'h8, 32'h0000_0000,  32'h12345678, 32'h12FEF00D};

        clrn = 1'b0; i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_i_ack",   {31'h0, i_ack}, 32'h0);
        check("rst_d_ack",   {31'h0, d_ack}, 32'h0);
        check("rst_i_rdata", i_rdata,        32'h0);
        check("rst_d_rdata", d_rdata,        32'h0);
        check("rst_mmio",    mmio_out,       32'h0);
        @(negedge clk) clrn = 1'b1;

        for (int v = 0; v < 11; v++) begin
            do_access(vecs[v].ch, vecs[v].we, vecs[v].be, vecs[v].addr, vecs[v].wdata, rd, lat);
            check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp);
            check($sformatf("vec%0d_latency", v), 32'(lat), 32'd3);
        end
        check("hold_i_rdata", i_rdata, 32'hCAFEF00D);
        check("hold_d_rdata", d_rdata, 32'h12FEF00D);

        // Reset during WAIT of a write to word 2: no ack, word kept.
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'd8; d_wdata = 32'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        clrn = 1'b0;
        #1;
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk) clrn = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            seen = seen | i_ack | d_ack;
        end
        check("abort_no_ack", {31'h0, seen}, 32'h0);
        do_access(1'b1, 1'b0, 4'h0, 32'd8, 32'h0, rd, lat);
        check("abort_word_kept", rd, 32'hAA22CC44);
        check("abort_fsm_idle_latency", 32'(lat), 32'd3);

        // Both channels held: DATA, INST, DATA, one grant per 4 cycles.
        @(negedge clk) clrn = 1'b0;
        @(negedge clk) clrn = 1'b1;
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'd16;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'd8;
        n_got = 0; dual = 1'b0;
        for (int k = 0; k < 3; k++) begin
            g_ch[k] = -1; g_cyc[k] = -100; g_dat[k] = 'x;
        end
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            dual = dual | (i_ack & d_ack);
            if (i_ack || d_ack) begin
                g_ch[n_got]  = d_ack ? 1 : 0;
                g_cyc[n_got] = c;
                g_dat[n_got] = d_ack ? d_rdata : i_rdata;
                n_got++;
                if (n_got == 3) break;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        check("arb_grants",      32'(n_got),  32'd3);
        check("arb_no_dual_ack", {31'h0, dual}, 32'h0);
        check("arb_first_data",  32'(g_ch[0]), 32'd1);
        check("arb_second_inst", 32'(g_ch[1]), 32'd0);
        check("arb_third_data",  32'(g_ch[2]), 32'd1);
        check("arb_first_cycle", 32'(g_cyc[0]), 32'd3);
        check("arb_gap1",        32'(g_cyc[1] - g_cyc[0]), 32'd4);
        check("arb_gap2",        32'(g_cyc[2] - g_cyc[1]), 32'd4);
        check("arb_d_rdata",     g_dat[0], 32'hAA22CC44);
        check("arb_i_rdata",     g_dat[1], 32'hDEADBEEF);

        // Output register at 0xFFFC.
        do_access(1'b1, 1'b1, 4'hF, 32'h0000_FFFC, 32'h0000_005A, rd, lat);
        check("mmio_wr_rdata",   rd,         32'h0000_005A);
        check("mmio_wr_latency", 32'(lat),   32'd3);
`ifdef MMIO_OUT_EN
        check("mmio_out_set", mmio_out, 32'h0000_005A);
        do_access(1'b1, 1'b0, 4'h0, 32'h0000_FFFC, 32'h0, rd, lat);
        check("mmio_rd_back", rd, 32'h0000_005A);
`else
        check("mmio_out_zero", mmio_out, 32'h0);
        do_access(1'b0, 1'b0, 4'h0, 32'h0000_FFFC, 32'h0, rd, lat);
        check("mmio_addr_in_array", rd, 32'h0000_005A);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
